// File: rtl/cv32e40p_apu_core_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cv32e40p_apu_core_pkg
// Brief    : APU port widths and request/response structs for the shared FPU.
// Revision : 1.0
// ============================================================================
package cv32e40p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  typedef struct packed {
    logic [APU_NARGS_CPU-1:0][31:0] operands;
    logic [APU_WOP_CPU-1:0]         op;
    logic [APU_NDSFLAGS_CPU-1:0]    flags;
  } apu_req_payload_t;

  typedef struct packed {
    logic [31:0]                 result;
    logic [APU_NUSFLAGS_CPU-1:0] rflags;
  } apu_rsp_t;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_apu_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_apu_arb_tag_fifo
// Brief    : Synchronous FIFO of owner tags; pointers wrap on power-of-2 depth.
// Revision : 1.0
// ============================================================================
module cv32e40p_apu_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [TAG_W-1:0]           tag_i,
  input  logic                       pop_i,
  output logic [TAG_W-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= tag_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));
`endif

endmodule
`default_nettype wire

// File: rtl/cv32e40p_apu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_apu_arbiter
// Brief    : Round-robin sharing of one FPU between cores with in-order response
//            steering. Define CV32E40P_APU_ARB_RSP_REG_EN to register responses.
// Revision : 1.0
// ============================================================================
module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [NUM_REQ-1:0]                          req_apu_req_i,
  output logic [NUM_REQ-1:0]                          req_apu_gnt_o,
  input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0] req_apu_operands_i,
  input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]         req_apu_op_i,
  input  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]    req_apu_flags_i,
  output logic [NUM_REQ-1:0]                          req_apu_rvalid_o,
  output logic [NUM_REQ-1:0][31:0]                    req_apu_result_o,
  output logic [NUM_REQ-1:0][APU_NUSFLAGS_CPU-1:0]    req_apu_rflags_o,
  output logic                                        apu_req_o,
  input  logic                                        apu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]              apu_operands_o,
  output logic [APU_WOP_CPU-1:0]                      apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]                 apu_flags_o,
  input  logic                                        apu_rvalid_i,
  input  logic [31:0]                                 apu_rdata_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]                 apu_rflags_i,
  output logic                                        apu_clk_en_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]        outstanding_o,
  output logic                                        rsp_err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               lock_q, lock_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               rsp_err_q, rsp_err_d;

  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand;
  logic [IDX_W-1:0]   sel_idx;
  logic               handshake;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [IDX_W-1:0]   fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic [NUM_REQ-1:0] pop_vec;

  apu_req_payload_t [NUM_REQ-1:0] payload;
  apu_req_payload_t               sel_payload;
  apu_rsp_t                       rsp_in;
  apu_rsp_t                       rsp_out;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_port
    assign payload[k] = '{operands: req_apu_operands_i[k],
                          op:       req_apu_op_i[k],
                          flags:    req_apu_flags_i[k]};
    assign req_apu_gnt_o[k]    = handshake & (sel_idx == IDX_W'(k));
    assign pop_vec[k]          = fifo_pop & (fifo_head == IDX_W'(k));
    assign req_apu_result_o[k] = rsp_out.result;
    assign req_apu_rflags_o[k] = rsp_out.rflags;
  end

  // First requester at or after rr_q, scanning modulo NUM_REQ.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_valid && req_apu_req_i[cand[IDX_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign sel_idx     = lock_q ? owner_q : win_idx;
  assign sel_payload = payload[sel_idx];
  assign apu_req_o   = (win_valid | lock_q) & ~fifo_full;
  assign handshake   = apu_req_o & apu_gnt_i;

  assign apu_operands_o = sel_payload.operands;
  assign apu_op_o       = sel_payload.op;
  assign apu_flags_o    = sel_payload.flags;

  always_comb begin
    rr_d    = rr_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    if (handshake) begin
      rr_d   = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
      lock_d = 1'b0;
    end else if (apu_req_o) begin
      lock_d  = 1'b1;
      owner_d = sel_idx;
    end
  end

  // A result with nothing outstanding has no owner: drop it and flag it.
  assign fifo_pop  = apu_rvalid_i & ~fifo_empty;
  assign rsp_err_d = rsp_err_q | (apu_rvalid_i & fifo_empty);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      owner_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  cv32e40p_apu_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .TAG_W (IDX_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .tag_i   (sel_idx),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rsp_in = '{result: apu_rdata_i, rflags: apu_rflags_i};

`ifdef CV32E40P_APU_ARB_RSP_REG_EN
  logic [NUM_REQ-1:0] rsp_valid_q;
  apu_rsp_t           rsp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= '0;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= pop_vec;
      if (fifo_pop) begin
        rsp_q <= rsp_in;
      end
    end
  end

  assign req_apu_rvalid_o = rsp_valid_q;
  assign rsp_out          = rsp_q;
`else
  assign req_apu_rvalid_o = pop_vec;
  assign rsp_out          = rsp_in;
`endif

  assign apu_clk_en_o  = apu_req_o | (fifo_count != '0) | (|req_apu_req_i);
  assign outstanding_o = fifo_count;
  assign rsp_err_o     = rsp_err_q;

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q |-> req_apu_req_i[owner_q]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_apu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_apu_arbiter
// Brief    : Self-checking bench for cv32e40p_apu_arbiter with queue-based model.
// Revision : 1.0
// ============================================================================
module tb_cv32e40p_apu_arbiter;
  import cv32e40p_apu_core_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int MAXO    = 4;
  localparam int CNT_W   = $clog2(MAXO + 1);
`ifdef CV32E40P_APU_ARB_RSP_REG_EN
  localparam int RSP_LAT = 1;
`else
  localparam int RSP_LAT = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [NUM_REQ-1:0]                          req;
  logic [NUM_REQ-1:0]                          gnt_o;
  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0] operands;
  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]         op;
  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]    flags;
  logic [NUM_REQ-1:0]                          rvalid_o;
  logic [NUM_REQ-1:0][31:0]                    result_o;
  logic [NUM_REQ-1:0][APU_NUSFLAGS_CPU-1:0]    rflags_o;
  logic                                        apu_req;
  logic                                        apu_gnt;
  logic [APU_NARGS_CPU-1:0][31:0]              apu_operands;
  logic [APU_WOP_CPU-1:0]                      apu_op;
  logic [APU_NDSFLAGS_CPU-1:0]                 apu_flags;
  logic                                        apu_rvalid;
  logic [31:0]                                 apu_rdata;
  logic [APU_NUSFLAGS_CPU-1:0]                 apu_rflags;
  logic                                        clk_en;
  logic [CNT_W-1:0]                            outstanding;
  logic                                        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  cv32e40p_apu_arbiter #(
    .NUM_REQ         (NUM_REQ),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_apu_req_i      (req),
    .req_apu_gnt_o      (gnt_o),
    .req_apu_operands_i (operands),
    .req_apu_op_i       (op),
    .req_apu_flags_i    (flags),
    .req_apu_rvalid_o   (rvalid_o),
    .req_apu_result_o   (result_o),
    .req_apu_rflags_o   (rflags_o),
    .apu_req_o          (apu_req),
    .apu_gnt_i          (apu_gnt),
    .apu_operands_o     (apu_operands),
    .apu_op_o           (apu_op),
    .apu_flags_o        (apu_flags),
    .apu_rvalid_i       (apu_rvalid),
    .apu_rdata_i        (apu_rdata),
    .apu_rflags_i       (apu_rflags),
    .apu_clk_en_o       (clk_en),
    .outstanding_o      (outstanding),
    .rsp_err_o          (rsp_err)
  );

  always #5 clk = ~clk;

  // Reference model: owner queue plus round-robin pointer and lock, as integers.
  int                          m_rr;
  bit                          m_lock;
  int                          m_owner;
  int                          m_q[$];
  bit                          m_err;
  logic [NUM_REQ-1:0]          m_rv_reg;
  logic [31:0]                 m_res_reg;
  logic [APU_NUSFLAGS_CPU-1:0] m_rfl_reg;

  logic                        e_req;
  int                          e_sel;
  logic [NUM_REQ-1:0]          e_gnt;
  logic [NUM_REQ-1:0]          e_rv;
  logic [31:0]                 e_res;
  logic [APU_NUSFLAGS_CPU-1:0] e_rfl;
  logic                        e_clken;
  int                          e_cnt;

  task automatic model_reset();
    m_rr      = 0;
    m_lock    = 1'b0;
    m_owner   = 0;
    m_q.delete();
    m_err     = 1'b0;
    m_rv_reg  = '0;
    m_res_reg = '0;
    m_rfl_reg = '0;
  endtask

  task automatic model_eval();
    bit found;
    int sel;
    int c;
    logic [NUM_REQ-1:0] rvc;
    found = 1'b0;
    sel   = 0;
    if (m_lock) begin
      found = 1'b1;
      sel   = m_owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (m_rr + k) % NUM_REQ;
        if (!found && req[c]) begin
          found = 1'b1;
          sel   = c;
        end
      end
    end
    e_sel = sel;
    e_req = found && (m_q.size() < MAXO);
    e_gnt = '0;
    if (e_req && apu_gnt) e_gnt[sel] = 1'b1;
    rvc = '0;
    if (apu_rvalid && m_q.size() > 0) rvc[m_q[0]] = 1'b1;
    if (RSP_LAT == 1) begin
      e_rv  = m_rv_reg;
      e_res = m_res_reg;
      e_rfl = m_rfl_reg;
    end else begin
      e_rv  = rvc;
      e_res = apu_rdata;
      e_rfl = apu_rflags;
    end
    e_cnt   = m_q.size();
    e_clken = e_req || (m_q.size() != 0) || (|req);
  endtask

  task automatic model_commit();
    bit pop;
    logic [NUM_REQ-1:0] rvc;
    pop = apu_rvalid && (m_q.size() > 0);
    rvc = '0;
    if (pop) rvc[m_q[0]] = 1'b1;
    if (apu_rvalid && m_q.size() == 0) m_err = 1'b1;
    m_rv_reg = rvc;
    if (pop) begin
      m_res_reg = apu_rdata;
      m_rfl_reg = apu_rflags;
      void'(m_q.pop_front());
    end
    if (e_req && apu_gnt) begin
      m_q.push_back(e_sel);
      m_rr   = (e_sel + 1) % NUM_REQ;
      m_lock = 1'b0;
    end else if (e_req) begin
      m_lock  = 1'b1;
      m_owner = e_sel;
    end
  endtask

  task automatic drive_idle();
    req        = '0;
    operands   = '0;
    op         = '0;
    flags      = '0;
    apu_gnt    = 1'b0;
    apu_rvalid = 1'b0;
    apu_rdata  = '0;
    apu_rflags = '0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (gnt_o !== '0) begin n_fail++; $display("FAIL reset_gnt got=%0h exp=0", gnt_o); end
    n_checks++; if (rvalid_o !== '0) begin n_fail++; $display("FAIL reset_rvalid got=%0h exp=0", rvalid_o); end
    n_checks++; if (result_o !== '0) begin n_fail++; $display("FAIL reset_result got=%0h exp=0", result_o); end
    n_checks++; if (apu_req !== 1'b0) begin n_fail++; $display("FAIL reset_apu_req got=%0h exp=0", apu_req); end
    n_checks++; if (apu_op !== '0) begin n_fail++; $display("FAIL reset_apu_op got=%0h exp=0", apu_op); end
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en got=%0h exp=0", clk_en); end
    n_checks++; if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding got=%0h exp=0", outstanding); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0h exp=0", rsp_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_core();
    logic [NUM_REQ-1:0] exp_rv;
    logic [31:0]        exp_res;
    do_reset();
    req[1] = 1'b1; op[1] = 6'd3; apu_gnt = 1'b1;
    settle();
    n_checks++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL single_gnt got=%0h exp=2", gnt_o); end
    n_checks++; if (apu_op !== 6'd3) begin n_fail++; $display("FAIL single_op got=%0h exp=3", apu_op); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL single_cnt0 got=%0h exp=0", outstanding); end
    model_commit();
    @(negedge clk);
    req = '0; apu_gnt = 1'b0;
    settle();
    n_checks++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL single_cnt1 got=%0h exp=1", outstanding); end
    model_commit();
    @(negedge clk);
    apu_rvalid = 1'b1; apu_rdata = 32'hDEAD_BEEF;
    settle();
    exp_rv  = (RSP_LAT == 0) ? 2'b10 : 2'b00;
    exp_res = (RSP_LAT == 0) ? 32'hDEAD_BEEF : 32'h0;
    n_checks++; if (rvalid_o !== exp_rv) begin n_fail++; $display("FAIL single_rv_c2 got=%0h exp=%0h", rvalid_o, exp_rv); end
    n_checks++; if (result_o[1] !== exp_res) begin n_fail++; $display("FAIL single_res_c2 got=%0h exp=%0h", result_o[1], exp_res); end
    model_commit();
    @(negedge clk);
    apu_rvalid = 1'b0; apu_rdata = '0;
    settle();
    exp_rv  = (RSP_LAT == 1) ? 2'b10 : 2'b00;
    exp_res = (RSP_LAT == 1) ? 32'hDEAD_BEEF : 32'h0;
    n_checks++; if (rvalid_o !== exp_rv) begin n_fail++; $display("FAIL single_rv_c3 got=%0h exp=%0h", rvalid_o, exp_rv); end
    n_checks++; if (result_o[1] !== exp_res) begin n_fail++; $display("FAIL single_res_c3 got=%0h exp=%0h", result_o[1], exp_res); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL single_cnt_end got=%0h exp=0", outstanding); end
    model_commit();
  endtask

  task automatic test_contention();
    logic [NUM_REQ-1:0] obs[$];
    logic [NUM_REQ-1:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = 2'b11; op[0] = 6'd1; op[1] = 6'd2; apu_gnt = 1'b1;
      settle();
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++; if (gnt_o !== exp) begin n_fail++; $display("FAIL contention_gnt%0d got=%0h exp=%0h", i, gnt_o, exp); end
      model_commit();
      @(negedge clk);
    end
    req = '0; apu_gnt = 1'b0;
    settle();
    n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL contention_cnt got=%0h exp=4", outstanding); end
    for (int i = 0; i < 5; i++) begin
      apu_rvalid = (i < 4);
      apu_rdata  = 32'(i);
      settle();
      if (rvalid_o !== '0) obs.push_back(rvalid_o);
      model_commit();
      @(negedge clk);
    end
    apu_rvalid = 1'b0;
    settle();
    n_checks++; if (obs.size() != 4) begin n_fail++; $display("FAIL contention_nrsp got=%0d exp=4", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++; if (obs[i] !== exp) begin n_fail++; $display("FAIL contention_rv%0d got=%0h exp=%0h", i, obs[i], exp); end
    end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL contention_cnt_end got=%0h exp=0", outstanding); end
    model_commit();
  endtask

  task automatic test_lock();
    do_reset();
    // Serve core 0 once so the pointer favours core 1 when unlocked.
    req = 2'b01; op[0] = 6'd7; apu_gnt = 1'b1;
    settle(); model_commit();
    @(negedge clk);
    req = 2'b01; op[0] = 6'd5; apu_gnt = 1'b0;
    settle();
    n_checks++; if (apu_req !== 1'b1) begin n_fail++; $display("FAIL lock_req got=%0h exp=1", apu_req); end
    n_checks++; if (apu_op !== 6'd5) begin n_fail++; $display("FAIL lock_op0 got=%0h exp=5", apu_op); end
    model_commit();
    @(negedge clk);
    for (int i = 1; i < 3; i++) begin
      req = 2'b11; op[1] = 6'd9;
      settle();
      n_checks++; if (apu_op !== 6'd5) begin n_fail++; $display("FAIL lock_op%0d got=%0h exp=5", i, apu_op); end
      n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL lock_gnt%0d got=%0h exp=0", i, gnt_o); end
      model_commit();
      @(negedge clk);
    end
    apu_gnt = 1'b1;
    settle();
    n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL lock_gnt_core0 got=%0h exp=1", gnt_o); end
    n_checks++; if (apu_op !== 6'd5) begin n_fail++; $display("FAIL lock_op_grant got=%0h exp=5", apu_op); end
    model_commit();
    @(negedge clk);
    req = 2'b10;
    settle();
    n_checks++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL lock_gnt_core1 got=%0h exp=2", gnt_o); end
    n_checks++; if (apu_op !== 6'd9) begin n_fail++; $display("FAIL lock_op_core1 got=%0h exp=9", apu_op); end
    model_commit();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = 2'b01; op[0] = 6'(i + 1); apu_gnt = 1'b1;
      settle();
      n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL full_fill_gnt%0d got=%0h exp=1", i, gnt_o); end
      model_commit();
      @(negedge clk);
    end
    op[0] = 6'd10;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++; if (apu_req !== 1'b0) begin n_fail++; $display("FAIL full_req%0d got=%0h exp=0", i, apu_req); end
      n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL full_gnt%0d got=%0h exp=0", i, gnt_o); end
      n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_cnt%0d got=%0h exp=4", i, outstanding); end
      n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL full_clk_en%0d got=%0h exp=1", i, clk_en); end
      model_commit();
      @(negedge clk);
    end
    apu_rvalid = 1'b1; apu_rdata = 32'h1234;
    settle();
    n_checks++; if (apu_req !== 1'b0) begin n_fail++; $display("FAIL full_req_pop got=%0h exp=0", apu_req); end
    n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL full_gnt_pop got=%0h exp=0", gnt_o); end
    model_commit();
    @(negedge clk);
    apu_rvalid = 1'b0;
    settle();
    n_checks++; if (apu_req !== 1'b1) begin n_fail++; $display("FAIL full_req_after got=%0h exp=1", apu_req); end
    n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL full_gnt_after got=%0h exp=1", gnt_o); end
    n_checks++; if (apu_op !== 6'd10) begin n_fail++; $display("FAIL full_op_after got=%0h exp=10", apu_op); end
    n_checks++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL full_cnt_after got=%0h exp=3", outstanding); end
    model_commit();
  endtask

  task automatic test_spurious_reset();
    do_reset();
    apu_rvalid = 1'b1; apu_rdata = 32'h55;
    settle();
    n_checks++; if (rvalid_o !== '0) begin n_fail++; $display("FAIL spur_rv got=%0h exp=0", rvalid_o); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL spur_err_before got=%0h exp=0", rsp_err); end
    model_commit();
    @(negedge clk);
    apu_rvalid = 1'b0; apu_rdata = '0;
    settle();
    n_checks++; if (rvalid_o !== '0) begin n_fail++; $display("FAIL spur_rv_next got=%0h exp=0", rvalid_o); end
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL spur_err got=%0h exp=1", rsp_err); end
    model_commit();
    @(negedge clk);
    req = 2'b11; apu_gnt = 1'b1;
    settle();
    n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL rst_fill_gnt0 got=%0h exp=1", gnt_o); end
    model_commit();
    @(negedge clk);
    req = 2'b10;
    settle();
    n_checks++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL rst_fill_gnt1 got=%0h exp=2", gnt_o); end
    model_commit();
    @(negedge clk);
    drive_idle();
    settle();
    n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL rst_pre_cnt got=%0h exp=2", outstanding); end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (outstanding !== '0) begin n_fail++; $display("FAIL rst_cnt got=%0h exp=0", outstanding); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0h exp=0", rsp_err); end
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL rst_clk_en got=%0h exp=0", clk_en); end
    n_checks++; if ({apu_req, gnt_o, rvalid_o} !== '0) begin n_fail++; $display("FAIL rst_hs got=%0h exp=0", {apu_req, gnt_o, rvalid_o}); end
    @(negedge clk);
    rst_n = 1'b1;
    apu_rvalid = 1'b1; apu_rdata = 32'hBAD;
    settle();
    n_checks++; if (rvalid_o !== '0) begin n_fail++; $display("FAIL rst_inflight_rv got=%0h exp=0", rvalid_o); end
    model_commit();
    @(negedge clk);
    apu_rvalid = 1'b0;
    settle();
    n_checks++; if (rvalid_o !== '0) begin n_fail++; $display("FAIL rst_inflight_rv2 got=%0h exp=0", rvalid_o); end
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL rst_inflight_err got=%0h exp=1", rsp_err); end
    model_commit();
  endtask

  task automatic test_random();
    bit act [NUM_REQ];
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) act[k] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!act[k] && ($urandom_range(0, 1) == 1)) begin
          act[k]   = 1'b1;
          op[k]    = APU_WOP_CPU'($urandom);
          flags[k] = APU_NDSFLAGS_CPU'($urandom);
          for (int j = 0; j < APU_NARGS_CPU; j++) operands[k][j] = $urandom;
        end
        req[k] = act[k];
      end
      apu_gnt    = ($urandom_range(0, 3) != 0);
      apu_rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      apu_rdata  = $urandom;
      apu_rflags = APU_NUSFLAGS_CPU'($urandom);
      settle();
      n_checks++; if (gnt_o !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%0h exp=%0h", cyc, gnt_o, e_gnt); end
      n_checks++; if (apu_req !== e_req) begin n_fail++; $display("FAIL rnd_req cyc=%0d got=%0h exp=%0h", cyc, apu_req, e_req); end
      n_checks++; if (rvalid_o !== e_rv) begin n_fail++; $display("FAIL rnd_rv cyc=%0d got=%0h exp=%0h", cyc, rvalid_o, e_rv); end
      n_checks++; if (outstanding !== CNT_W'(e_cnt)) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0h exp=%0h", cyc, outstanding, e_cnt); end
      n_checks++; if (rsp_err !== m_err) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%0h exp=%0h", cyc, rsp_err, m_err); end
      n_checks++; if (clk_en !== e_clken) begin n_fail++; $display("FAIL rnd_clk_en cyc=%0d got=%0h exp=%0h", cyc, clk_en, e_clken); end
      if (e_req) begin
        n_checks++; if (apu_op !== op[e_sel]) begin n_fail++; $display("FAIL rnd_op cyc=%0d got=%0h exp=%0h", cyc, apu_op, op[e_sel]); end
        n_checks++; if (apu_operands !== operands[e_sel]) begin n_fail++; $display("FAIL rnd_operands cyc=%0d got=%0h exp=%0h", cyc, apu_operands, operands[e_sel]); end
        n_checks++; if (apu_flags !== flags[e_sel]) begin n_fail++; $display("FAIL rnd_flags cyc=%0d got=%0h exp=%0h", cyc, apu_flags, flags[e_sel]); end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (e_rv[k]) begin
          n_checks++; if (result_o[k] !== e_res) begin n_fail++; $display("FAIL rnd_res%0d cyc=%0d got=%0h exp=%0h", k, cyc, result_o[k], e_res); end
          n_checks++; if (rflags_o[k] !== e_rfl) begin n_fail++; $display("FAIL rnd_rflags%0d cyc=%0d got=%0h exp=%0h", k, cyc, rflags_o[k], e_rfl); end
        end
        if (e_gnt[k]) act[k] = 1'b0;
      end
      model_commit();
      @(negedge clk);
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_single_core();
    test_contention();
    test_lock();
    test_full();
    test_random();
    test_spurious_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
